serial_tx: RTL and testbench
============================

# serial_tx

Framed parallel-in/serial-out transmitter that generates the single-bit `d` stream consumed by the serial shift-register stages (`block`/`nonblock`). It accepts a parallel word through a valid/ready handshake and serializes it MSB-first as a start bit, data bits, an optional even-parity bit, and a stop bit. Each bit is held for a programmable number of clock cycles. It is the producer end of the serial link; the shift-register chain is the consumer.

## Interface
- `WIDTH`, 8, data word width in bits (≥1).
- `CLKS_PER_BIT`, 1, clock cycles each serial bit is held (≥1).
- `PARITY_EN`, 0, 1 inserts an even-parity bit after the data bits; 0 omits it.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `din`  input  WIDTH  parallel word to send; sampled only on the accepting edge.
- `din_valid`  input  1  `din` is valid.
- `din_ready`  output  1  block can accept a word this cycle.
- `q`  output  1  serial output; idle level is 1.
- `busy`  output  1  a frame is in progress.
- `done`  output  1  one-cycle pulse after the stop bit completes.

## Operation
- All outputs are registered. Reset values: `q`=1, `din_ready`=1, `busy`=0, `done`=0. The state machine resets to IDLE and the counters reset to 0.
- State machine:
  - IDLE: `q`=1, `din_ready`=1. When `din_valid && din_ready` at an edge, capture `din` into the shift register, compute parity, and go to START.
  - START: `q`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `q` = current MSB of the shift register. Each bit is held CLKS_PER_BIT cycles, then the register shifts left. After WIDTH bits, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: `q` = XOR of all captured data bits, held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `q`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT), with a minimum of 1 bit.
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - When CLKS_PER_BIT=1, every cycle is a bit boundary.
- Bit counter:
  - Width is clog2(WIDTH+1).
  - Counts data bits 0..WIDTH-1 in DATA.
  - Cleared on entry to START.
- `busy`=1 in START, DATA, PARITY and STOP; `din_ready` = !`busy`.
- `done`=1 for exactly one cycle: the first IDLE cycle after STOP ends. `din_ready` is also 1 in that cycle, so a new word may be accepted there.
- `din` and `din_valid` are ignored while `busy`=1. Changes to `din` mid-frame do not affect the frame in flight.
- `rst` asserted in any state: on the next edge `q`=1 and `din_ready`=1. The frame is discarded and no `done` pulse is produced. `rst` has priority over `din_valid`.

## Timing
- Accepting edge is T0. The start bit appears on `q` in cycle T0+1. `busy` rises in the same cycle.
- Frame length is N = (WIDTH+2+PARITY_EN)×CLKS_PER_BIT cycles, covering cycles T0+1 .. T0+N.
- `done`=1 and `din_ready`=1 in cycle T0+N+1.
- With `din_valid` held high continuously, frames repeat every N+1 cycles. There is exactly one idle (`q`=1) cycle between the stop bit and the next start bit.
- Data bit k (MSB is k=0) occupies cycles T0+(1+k)×CLKS_PER_BIT+1 .. T0+(2+k)×CLKS_PER_BIT.

## Test plan
- **Single frame, WIDTH=8, CLKS_PER_BIT=1, PARITY_EN=0.**
  - Stimulus: `din`=8'hA5 accepted at T0.
  - Required `q` over T0+1..T0+10: 0,1,0,1,0,0,1,0,1,1.
  - Required `done`=1 only at T0+11; `busy`=1 over T0+1..T0+10.
- **Parity on, CLKS_PER_BIT=1.**
  - Stimulus: 8'hA5, then 8'h07.
  - Required parity bit at T0+10: 0 for 8'hA5, 1 for 8'h07.
  - Required stop bit at T0+11 and `done` at T0+12.
- **CLKS_PER_BIT=4.**
  - Stimulus: `din`=8'h80.
  - Required: start bit low for 4 cycles, then `q` high for 4 cycles (MSB), then low for 28 cycles, then stop bit high for 4 cycles.
  - Required: `done` at T0+41.
- **Back-to-back.**
  - Stimulus: `din_valid`=1 continuously with `din` = 8'h3C, then 8'hC3.
  - Required: second start bit at T0+12; `din_ready`=0 throughout both frames except at T0+11.
- **Mid-frame reset.**
  - Stimulus: `rst`=1 for one cycle during DATA bit 3 of 8'hFF.
  - Required on the next edge: `q`=1, `busy`=0, `din_ready`=1, `done`=0.
  - Required: a new frame sent afterward is correct.
- **Input stability.**
  - Stimulus: toggle `din` and `din_valid` every cycle during a frame.
  - Required: serialized bits match the word captured at T0, and no second frame is accepted until `din_ready`=1.

Source files
------------

// File: rtl/serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, MSB-first data, optional
// even parity, stop bit, each bit held for CLKS_PER_BIT clock cycles.
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             q,
    output logic             busy,
    output logic             done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic             q_q, q_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             boundary;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            q_q     <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        done_d   = 1'b0;
        boundary = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_d = boundary ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (din_valid && din_ready) begin
                    state_d = START;
                    shift_d = din;
                    par_d   = ^din;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (boundary) state_d = DATA;
            end
            DATA: begin
                if (boundary) begin
                    shift_d = shift_q << 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (boundary) state_d = STOP;
            end
            STOP: begin
                if (boundary) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        unique case (state_d)
            START:   q_d = 1'b0;
            DATA:    q_d = shift_d[WIDTH-1];
            PARITY:  q_d = par_d;
            default: q_d = 1'b1;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = !busy_d;
    end

    assign q         = q_q;
    assign busy      = busy_q;
    assign din_ready = ready_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: three instances (plain, parity, 4 clocks/bit)
// compared cycle by cycle against a frame model built from the bit layout.
module tb_serial_tx;

    logic           clk;
    logic [2:0]     rst_v;
    logic [2:0]     dv_v;
    logic [2:0][7:0] din_v;
    logic [2:0]     rdy_v;
    logic [2:0]     q_v;
    logic [2:0]     busy_v;
    logic [2:0]     done_v;

    int tests;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_plain (
        .clk(clk), .rst(rst_v[0]), .din(din_v[0]), .din_valid(dv_v[0]),
        .din_ready(rdy_v[0]), .q(q_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_par (
        .clk(clk), .rst(rst_v[1]), .din(din_v[1]), .din_valid(dv_v[1]),
        .din_ready(rdy_v[1]), .q(q_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_slow (
        .clk(clk), .rst(rst_v[2]), .din(din_v[2]), .din_valid(dv_v[2]),
        .din_ready(rdy_v[2]), .q(q_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    function automatic int cpb_of(input int u);
        return (u == 2) ? 4 : 1;
    endfunction

    function automatic int par_of(input int u);
        return (u == 1) ? 1 : 0;
    endfunction

    function automatic int frame_len(input int u);
        return (8 + 2 + par_of(u)) * cpb_of(u);
    endfunction

    // Expected q in cycle T0+k (1 <= k <= frame length) for word w.
    function automatic logic exp_bit(input logic [7:0] w, input int u, input int k);
        int slot;
        slot = (k - 1) / cpb_of(u);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return w[8 - slot];
        if (slot == 9 && par_of(u) != 0) return ^w;
        return 1'b1;
    endfunction

    // Sends one word on unit u and checks every cycle through the done pulse.
    // With toggle=1, din/din_valid are scrambled while the frame is in flight.
    task automatic drive_frame(input int u, input logic [7:0] w, input bit toggle, input string tag);
        int n;
        logic eq, eb;
        n = frame_len(u);
        @(negedge clk);
        tests++;
        if (rdy_v[u] !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_before_accept u=%0d got %b exp 1", tag, u, rdy_v[u]);
        end
        din_v[u] = w;
        dv_v[u]  = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= n + 1; k++) begin
            eq = (k <= n) ? exp_bit(w, u, k) : 1'b1;
            eb = (k <= n);
            tests += 4;
            if (q_v[u] !== eq) begin
                fails++;
                $display("FAIL %s q u=%0d w=%h k=%0d got %b exp %b", tag, u, w, k, q_v[u], eq);
            end
            if (busy_v[u] !== eb) begin
                fails++;
                $display("FAIL %s busy u=%0d k=%0d got %b exp %b", tag, u, k, busy_v[u], eb);
            end
            if (rdy_v[u] !== !eb) begin
                fails++;
                $display("FAIL %s ready u=%0d k=%0d got %b exp %b", tag, u, k, rdy_v[u], !eb);
            end
            if (done_v[u] !== (k == n + 1)) begin
                fails++;
                $display("FAIL %s done u=%0d k=%0d got %b exp %b", tag, u, k, done_v[u], (k == n + 1));
            end
            if (toggle && k <= n) begin
                dv_v[u]  = 1'($urandom_range(1));
                din_v[u] = 8'($urandom);
            end else begin
                dv_v[u] = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        tests += 2;
        if (q_v[u] !== 1'b1 || busy_v[u] !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_after u=%0d got q=%b busy=%b exp q=1 busy=0", tag, u, q_v[u], busy_v[u]);
        end
        if (done_v[u] !== 1'b0) begin
            fails++;
            $display("FAIL %s done_width u=%0d got %b exp 0", tag, u, done_v[u]);
        end
    endtask

    task automatic test_reset();
        rst_v = 3'b111;
        dv_v  = 3'b000;
        din_v = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            tests++;
            if ({q_v[u], rdy_v[u], busy_v[u], done_v[u]} !== 4'b1100) begin
                fails++;
                $display("FAIL reset u=%0d got q,rdy,busy,done=%b exp 1100", u,
                         {q_v[u], rdy_v[u], busy_v[u], done_v[u]});
            end
        end
        @(negedge clk);
        rst_v = 3'b000;
        $display("[TB] reset checked");
    endtask

    task automatic test_directed();
        drive_frame(0, 8'hA5, 1'b0, "a5_plain");
        $display("[TB] frame 8'hA5 plain");
        drive_frame(1, 8'hA5, 1'b0, "a5_parity");
        $display("[TB] frame 8'hA5 parity");
        drive_frame(1, 8'h07, 1'b0, "07_parity");
        $display("[TB] frame 8'h07 parity");
        drive_frame(2, 8'h80, 1'b0, "80_slow");
        $display("[TB] frame 8'h80 4 clocks/bit");
    endtask

    task automatic test_random();
        logic [7:0] w;
        for (int i = 0; i < 12; i++) begin
            w = 8'($urandom);
            drive_frame(i % 3, w, 1'b0, "random");
            $display("[TB] random frame u=%0d w=%h", i % 3, w);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        int kk;
        logic eq, eb;
        @(negedge clk);
        din_v[0] = 8'h3C;
        dv_v[0]  = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 22; k++) begin
            kk = (k <= 11) ? k : k - 11;
            w  = (k <= 11) ? 8'h3C : 8'hC3;
            eq = (kk <= 10) ? exp_bit(w, 0, kk) : 1'b1;
            eb = (kk <= 10);
            tests += 3;
            if (q_v[0] !== eq) begin
                fails++;
                $display("FAIL b2b q k=%0d got %b exp %b", k, q_v[0], eq);
            end
            if (rdy_v[0] !== !eb) begin
                fails++;
                $display("FAIL b2b ready k=%0d got %b exp %b", k, rdy_v[0], !eb);
            end
            if (done_v[0] !== (kk == 11)) begin
                fails++;
                $display("FAIL b2b done k=%0d got %b exp %b", k, done_v[0], (kk == 11));
            end
            if (k == 1) din_v[0] = 8'hC3;
            if (k == 12) dv_v[0] = 1'b0;
            @(posedge clk);
            #1;
        end
        $display("[TB] back-to-back 8'h3C then 8'hC3");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        din_v[0] = 8'hFF;
        dv_v[0]  = 1'b1;
        @(posedge clk);
        #1;
        dv_v[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tests++;
            if (q_v[0] !== exp_bit(8'hFF, 0, k)) begin
                fails++;
                $display("FAIL midrst pre q k=%0d got %b exp %b", k, q_v[0], exp_bit(8'hFF, 0, k));
            end
            if (k < 5) begin
                @(posedge clk);
                #1;
            end
        end
        rst_v[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        tests++;
        if ({q_v[0], busy_v[0], rdy_v[0], done_v[0]} !== 4'b1010) begin
            fails++;
            $display("FAIL midrst outputs got q,busy,rdy,done=%b exp 1010",
                     {q_v[0], busy_v[0], rdy_v[0], done_v[0]});
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            tests++;
            if (done_v[0] !== 1'b0 || q_v[0] !== 1'b1) begin
                fails++;
                $display("FAIL midrst quiet k=%0d got done=%b q=%b exp done=0 q=1", k, done_v[0], q_v[0]);
            end
        end
        drive_frame(0, 8'($urandom), 1'b0, "after_reset");
        $display("[TB] mid-frame reset");
    endtask

    task automatic test_input_stability();
        for (int u = 0; u < 3; u++) begin
            drive_frame(u, 8'($urandom), 1'b1, "stability");
            $display("[TB] input stability u=%0d", u);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_reset();
        test_input_stability();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
